fifo_sync_prog: RTL and testbench

//  Parametrised synchronous FIFO, next generation of the UART TX/RX buffer.

---
 rtl/fifo_sync_prog_pkg.sv | 20 ++
 rtl/fifo_mem_2p.sv | 30 +++
 rtl/fifo_sync_prog.sv | 150 +++++++++++++++
 tb/tb_fifo_sync_prog.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_prog_pkg.sv
// Shared definitions for the programmable synchronous FIFO: read-mode codes,
// count update encoding and the depth helper.
package fifo_sync_prog_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Occupancy update selected by {write accepted, read accepted}
    typedef enum logic [1:0] {
        CNT_HOLD = 2'b00,
        CNT_DEC  = 2'b01,
        CNT_INC  = 2'b10,
        CNT_SWAP = 2'b11
    } cnt_op_e;

    function automatic int fifo_depth(input int addr_w);
        return 32'sd1 << addr_w;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DATA_W x 2**ADDR_W register array, one synchronous write port and one
// asynchronous read port. Contents are deliberately never reset.
module fifo_mem_2p
    import fifo_sync_prog_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = fifo_depth(ADDR_W);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// standard or first-word-fall-through read mode, sticky error flags and flush.
module fifo_sync_prog
    import fifo_sync_prog_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int FWFT   = 0
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              flush,
    input  logic              err_clr,
    input  logic [ADDR_W:0]   almst_full_th,
    input  logic [ADDR_W:0]   almst_empty_th,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [ADDR_W:0]   data_count,
    output logic              empty,
    output logic              full,
    output logic              almst_empty,
    output logic              almst_full,
    output logic              ovf,
    output logic              udf
);

    localparam logic [ADDR_W:0] CNT_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_ovf;
    logic              r_udf;

    logic              w_empty;
    logic              w_full;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_mem_we;
    logic              w_ovf_set;
    logic              w_udf_set;
    logic [DATA_W-1:0] w_rd_data;
    cnt_op_e           w_cnt_op;

    // Flags come straight from the registered count so they cannot glitch
    assign w_empty  = (r_count == CNT_ZERO);
    assign w_full   = (r_count == CNT_DEPTH);
    assign w_rd_acc = rd_en & ~w_empty;
    assign w_wr_acc = wr_en & (~w_full | w_rd_acc);
    assign w_cnt_op = cnt_op_e'({w_wr_acc, w_rd_acc});

    // A write in the reset or flush cycle must not land in the array
    assign w_mem_we  = n_reset & ~flush & w_wr_acc;
    assign w_ovf_set = ~flush & wr_en & ~w_wr_acc;
    assign w_udf_set = ~flush & rd_en & ~w_rd_acc;

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_rd_data)
    );

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_wr_ptr <= CNT_ZERO;
            r_rd_ptr <= CNT_ZERO;
            r_count  <= CNT_ZERO;
        end else if (flush) begin
            r_wr_ptr <= CNT_ZERO;
            r_rd_ptr <= CNT_ZERO;
            r_count  <= CNT_ZERO;
        end else begin
            r_wr_ptr <= r_wr_ptr + {{ADDR_W{1'b0}}, w_wr_acc};
            r_rd_ptr <= r_rd_ptr + {{ADDR_W{1'b0}}, w_rd_acc};
            case (w_cnt_op)
                CNT_INC:  r_count <= r_count + CNT_ONE;
                CNT_DEC:  r_count <= r_count - CNT_ONE;
                CNT_HOLD: r_count <= r_count;
                CNT_SWAP: r_count <= r_count;
                default:  r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~err_clr);
            r_udf <= w_udf_set | (r_udf & ~err_clr);
        end
    end

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head word is presented as soon as the FIFO is non-empty
            always_comb begin
                if (w_empty) begin
                    data_out = {DATA_W{1'b0}};
                end else begin
                    data_out = w_rd_data;
                end
            end
            assign data_valid = ~w_empty;
        end else begin : g_std
            logic [DATA_W-1:0] r_data_out;
            logic              r_data_valid;

            // One-cycle read latency; data_out holds between reads
            always_ff @(posedge clk) begin
                if (!n_reset) begin
                    r_data_out   <= {DATA_W{1'b0}};
                    r_data_valid <= 1'b0;
                end else if (flush) begin
                    r_data_valid <= 1'b0;
                end else if (w_rd_acc) begin
                    r_data_out   <= w_rd_data;
                    r_data_valid <= 1'b1;
                end else begin
                    r_data_valid <= 1'b0;
                end
            end
            assign data_out   = r_data_out;
            assign data_valid = r_data_valid;
        end
    endgenerate

    assign data_count  = r_count;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almst_empty = (r_count <= almst_empty_th);
    assign almst_full  = (r_count >= almst_full_th);
    assign ovf         = r_ovf;
    assign udf         = r_udf;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Self-checking bench: standard and FWFT instances share stimulus and are
// compared every cycle against a queue-based reference model.
module tb_fifo_sync_prog;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int DEPTH = 8;

    logic          clk;
    logic          n_reset;
    logic [DW-1:0] data_in;
    logic          wr_en, rd_en, flush, err_clr;
    logic [AW:0]   af_th, ae_th;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_dv, f_dv;
    logic [AW:0]   s_cnt, f_cnt;
    logic          s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
    logic          f_empty, f_full, f_ae, f_af, f_ovf, f_udf;

    fifo_sync_prog #(.DATA_W(DW), .ADDR_W(AW), .FWFT(0)) dut_std (
        .clk(clk), .n_reset(n_reset), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .flush(flush), .err_clr(err_clr), .almst_full_th(af_th), .almst_empty_th(ae_th),
        .data_out(s_dout), .data_valid(s_dv), .data_count(s_cnt), .empty(s_empty),
        .full(s_full), .almst_empty(s_ae), .almst_full(s_af), .ovf(s_ovf), .udf(s_udf));

    fifo_sync_prog #(.DATA_W(DW), .ADDR_W(AW), .FWFT(1)) dut_fwft (
        .clk(clk), .n_reset(n_reset), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .flush(flush), .err_clr(err_clr), .almst_full_th(af_th), .almst_empty_th(ae_th),
        .data_out(f_dout), .data_valid(f_dv), .data_count(f_cnt), .empty(f_empty),
        .full(f_full), .almst_empty(f_ae), .almst_full(f_af), .ovf(f_ovf), .udf(f_udf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic          m_ovf, m_udf, m_dv;
    logic [DW-1:0] m_dout;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        bit rd_ok, wr_ok;
        if (!n_reset) begin
            q.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_dv = 1'b0; m_dout = 8'h00;
        end else if (flush) begin
            q.delete();
            m_dv = 1'b0;
            if (err_clr) begin m_ovf = 1'b0; m_udf = 1'b0; end
        end else begin
            rd_ok = rd_en && (q.size() > 0);
            wr_ok = wr_en && ((q.size() < DEPTH) || rd_ok);
            if (wr_en && !wr_ok) m_ovf = 1'b1;
            else if (err_clr)    m_ovf = 1'b0;
            if (rd_en && !rd_ok) m_udf = 1'b1;
            else if (err_clr)    m_udf = 1'b0;
            if (rd_ok) begin
                m_dout = q.pop_front();
                m_dv = 1'b1;
            end else begin
                m_dv = 1'b0;
            end
            if (wr_ok) q.push_back(data_in);
        end
    endtask

    task automatic check_all();
        int c;
        logic [DW-1:0] head;
        c = q.size();
        head = (c > 0) ? q[0] : 8'h00;
        check_eq("count",        32'(s_cnt),   32'(c));
        check_eq("empty",        32'(s_empty), 32'(c == 0));
        check_eq("full",         32'(s_full),  32'(c == DEPTH));
        check_eq("almst_empty",  32'(s_ae),    32'(c <= int'(ae_th)));
        check_eq("almst_full",   32'(s_af),    32'(c >= int'(af_th)));
        check_eq("ovf",          32'(s_ovf),   32'(m_ovf));
        check_eq("udf",          32'(s_udf),   32'(m_udf));
        check_eq("std_dvalid",   32'(s_dv),    32'(m_dv));
        check_eq("std_dout",     32'(s_dout),  32'(m_dout));
        check_eq("fwft_count",   32'(f_cnt),   32'(c));
        check_eq("fwft_ovf_udf", 32'({f_ovf, f_udf}), 32'({m_ovf, m_udf}));
        check_eq("fwft_dvalid",  32'(f_dv),    32'(c != 0));
        check_eq("fwft_dout",    32'(f_dout),  32'(head));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0; n_reset = 1'b1;
    endtask

    initial begin
        n_reset = 1'b0; data_in = 8'h00; wr_en = 1'b0; rd_en = 1'b0;
        flush = 1'b0; err_clr = 1'b0; af_th = 4'd0; ae_th = 4'd2;
        m_ovf = 1'b0; m_udf = 1'b0; m_dv = 1'b0; m_dout = 8'h00;
        step(); step();
        check_eq("reset_af_th0", 32'(s_af), 32'd1);
        af_th = 4'd6;
        #1;
        check_eq("reset_af_th6", 32'(s_af), 32'd0);
        idle();

        // Fill, overflow, drain
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1; data_in = 8'(i); step();
        end
        check_eq("fill_full", 32'(s_full), 32'd1);
        data_in = 8'hAA; step();
        check_eq("ovf_set", 32'(s_ovf), 32'd1);
        wr_en = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            rd_en = 1'b1; step();
            check_eq("drain_data", 32'(s_dout), 32'(i));
        end
        rd_en = 1'b0; err_clr = 1'b1; step(); err_clr = 1'b0;
        check_eq("drain_empty", 32'(s_empty), 32'd1);

        // Simultaneous read/write at empty and at full
        wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h55; step();
        check_eq("empty_rw_udf", 32'(s_udf), 32'd1);
        check_eq("empty_rw_cnt", 32'(s_cnt), 32'd1);
        rd_en = 1'b0; err_clr = 1'b1;
        for (int i = 0; i < 7; i++) begin data_in = 8'(8'h60 + i); step(); err_clr = 1'b0; end
        rd_en = 1'b1; data_in = 8'h99; step();
        check_eq("full_rw_cnt",  32'(s_cnt),  32'd8);
        check_eq("full_rw_ovf",  32'(s_ovf),  32'd0);
        check_eq("full_rw_data", 32'(s_dout), 32'h55);
        idle(); flush = 1'b1; step(); flush = 1'b0;

        // Threshold sweep with a same-cycle threshold change at count 5
        af_th = 4'd6; ae_th = 4'd2;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) begin
                af_th = 4'd4;
                #1;
                check_eq("af_change_same_cycle", 32'(s_af), 32'd1);
                af_th = 4'd6;
                #1;
            end
            wr_en = 1'b1; data_in = 8'(i); step();
        end
        idle(); flush = 1'b1; step(); flush = 1'b0;

        // FWFT fall-through latency
        wr_en = 1'b1; data_in = 8'h3C; step();
        check_eq("fwft_first", 32'(f_dout), 32'h3C);
        check_eq("fwft_valid", 32'(f_dv), 32'd1);
        wr_en = 1'b0; rd_en = 1'b1; step(); rd_en = 1'b0;
        check_eq("fwft_empty", 32'(f_empty), 32'd1);

        // Wrap-around with interleaved write/read pairs
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; rd_en = 1'b0; data_in = 8'(i); step();
            wr_en = 1'b0; rd_en = 1'b1; step();
            check_eq("wrap_order", 32'(s_dout), 32'(i));
        end
        idle();

        // Flush with a concurrent write, then reset mid-burst
        for (int i = 0; i < 5; i++) begin wr_en = 1'b1; data_in = 8'(8'hC0 + i); step(); end
        flush = 1'b1; step(); flush = 1'b0;
        check_eq("flush_cnt", 32'(s_cnt), 32'd0);
        check_eq("flush_ovf", 32'(s_ovf), 32'd0);
        for (int i = 0; i < 10; i++) begin data_in = 8'(8'hD0 + i); step(); end
        n_reset = 1'b0; data_in = 8'hEE; step();
        check_eq("rst_mid_cnt", 32'(s_cnt), 32'd0);
        check_eq("rst_mid_ovf", 32'(s_ovf), 32'd0);
        n_reset = 1'b1;
        for (int i = 0; i < 9; i++) begin data_in = 8'(i); step(); end
        wr_en = 1'b0; err_clr = 1'b1; step(); err_clr = 1'b0;
        check_eq("err_clr_ovf", 32'(s_ovf), 32'd0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            data_in = 8'($urandom);
            wr_en   = ($urandom_range(0, 99) < 55);
            rd_en   = ($urandom_range(0, 99) < 50);
            flush   = ($urandom_range(0, 99) < 3);
            err_clr = ($urandom_range(0, 99) < 8);
            n_reset = ($urandom_range(0, 99) >= 2);
            if ($urandom_range(0, 99) < 10) begin
                af_th = 4'($urandom_range(0, 15));
                ae_th = 4'($urandom_range(0, 15));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
